// File: rtl/message_scroller.sv
// message_scroller
//
// Scrolls a stored message of character codes across a row of active-low
// seven-segment digits. In edit mode (WE=1) the message RAM is written and the
// display is frozen; in scroll mode (WE=0) a prescaler produces one tick every
// TICK_DIV clocks, and each tick pushes the next message character in at
// digit 0 while the older characters move towards digit DIGITS-1.
//
// Ports:
//   clock     sole clock, rising edge
//   Reset_n   asynchronous active-low reset (RAM contents are kept)
//   WE        1 = edit mode, 0 = scroll mode
//   wr_valid  RAM write strobe, only honoured while WE=1
//   wr_addr   RAM write address
//   wr_data   character code to write
//   msg_len   message length, sampled on the first scroll-mode clock
//   pause     1 = freeze prescaler and read pointer
//   Dout      segment bus, digit k in [7k+6:7k], digit 0 = newest character
//   wrap      one-cycle pulse when the last message character is shifted in

module message_scroller #(
    parameter int DIGITS   = 6,
    parameter int DEPTH    = 32,
    parameter int CODE_W   = 5,
    parameter int TICK_DIV = 25_000_000,
    localparam int AW      = $clog2(DEPTH),
    localparam int SEG_W   = 7
) (
    input  logic                      clock,
    input  logic                      Reset_n,
    input  logic                      WE,
    input  logic                      wr_valid,
    input  logic [AW-1:0]             wr_addr,
    input  logic [CODE_W-1:0]         wr_data,
    input  logic [AW:0]               msg_len,
    input  logic                      pause,
    output logic [DIGITS*SEG_W-1:0]   Dout,
    output logic                      wrap
);

    localparam int LW = AW + 1;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0]    TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [LW-1:0]    FULL_LEN  = LW'(DEPTH);
    localparam logic [SEG_W-1:0] BLANK     = 7'h7F;

    // Character code to active-low {g,f,e,d,c,b,a} pattern.
    function automatic logic [SEG_W-1:0] decodeSeg(input logic [CODE_W-1:0] code);
        logic [31:0] c;
        logic [SEG_W-1:0] seg;
        c = 32'(code);
        case (c)
            0:       seg = 7'h40;
            1:       seg = 7'h79;
            2:       seg = 7'h24;
            3:       seg = 7'h30;
            4:       seg = 7'h19;
            5:       seg = 7'h12;
            6:       seg = 7'h02;
            7:       seg = 7'h78;
            8:       seg = 7'h00;
            9:       seg = 7'h10;
            10:      seg = 7'h08;
            11:      seg = 7'h03;
            12:      seg = 7'h46;
            13:      seg = 7'h21;
            14:      seg = 7'h06;
            15:      seg = 7'h0E;
            31:      seg = 7'h3F;
            default: seg = BLANK;
        endcase
        return seg;
    endfunction

    logic [CODE_W-1:0]       mem [DEPTH];

    logic                    editSeen;
    logic [LW-1:0]           lenReg;
    logic [PW-1:0]           prescaler;
    logic [AW-1:0]           rdPtr;

    logic                    rdValid;
    logic                    rdLast;
    logic [CODE_W-1:0]       rdCode;

    logic                    decValid;
    logic                    decLast;
    logic [SEG_W-1:0]        decSeg;

    logic [DIGITS*SEG_W-1:0] dispReg;
    logic [DIGITS*SEG_W-1:0] dispShifted;

    logic                    tick;
    logic                    ptrAtEnd;
    logic [LW-1:0]           lenSampled;

    // Tick, end-of-message detect, length clamp and the shifted display image.
    // A zero or oversized length means "use the whole RAM".
    always_comb begin
        tick        = !pause && (prescaler == TICK_LAST);
        ptrAtEnd    = ({1'b0, rdPtr} == (lenReg - LW'(1)));
        lenSampled  = ((msg_len == '0) || (msg_len > FULL_LEN)) ? FULL_LEN : msg_len;
        dispShifted = dispReg << SEG_W;
        dispShifted[SEG_W-1:0] = decSeg;
    end

    // Message RAM: write port only active in edit mode, no reset so the
    // message survives a reset.
    always_ff @(posedge clock) begin
        if (WE && wr_valid) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Scroll engine. Three registered stages per character: the tick edge
    // issues the RAM read, the next edge registers the decoded pattern, and
    // the edge after that shifts it into the display. editSeen remembers
    // that the previous clock was in edit mode so the first scroll clock can
    // restart everything from a blank display; reset sets it so that a reset
    // during scrolling also restarts cleanly.
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            editSeen  <= 1'b1;
            lenReg    <= FULL_LEN;
            prescaler <= '0;
            rdPtr     <= '0;
            rdValid   <= 1'b0;
            rdLast    <= 1'b0;
            rdCode    <= '0;
            decValid  <= 1'b0;
            decLast   <= 1'b0;
            decSeg    <= BLANK;
            dispReg   <= '1;
            wrap      <= 1'b0;
        end else begin
            editSeen <= WE;
            if (WE) begin
                // Edit mode: display held, anything in flight is dropped.
                prescaler <= '0;
                rdPtr     <= '0;
                rdValid   <= 1'b0;
                decValid  <= 1'b0;
                wrap      <= 1'b0;
            end else if (editSeen) begin
                lenReg    <= lenSampled;
                prescaler <= '0;
                rdPtr     <= '0;
                rdValid   <= 1'b0;
                decValid  <= 1'b0;
                dispReg   <= '1;
                wrap      <= 1'b0;
            end else begin
                if (!pause) begin
                    prescaler <= tick ? '0 : prescaler + PW'(1);
                end
                rdValid <= tick;
                if (tick) begin
                    rdCode <= mem[rdPtr];
                    rdLast <= ptrAtEnd;
                    rdPtr  <= ptrAtEnd ? '0 : rdPtr + AW'(1);
                end
                decValid <= rdValid;
                decSeg   <= decodeSeg(rdCode);
                decLast  <= rdLast;
                if (decValid) begin
                    dispReg <= dispShifted;
                    wrap    <= decLast;
                end else begin
                    wrap    <= 1'b0;
                end
            end
        end
    end

    assign Dout = dispReg;

endmodule
